// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and a mul/div freeze FSM,
// plus a saturating stall-cycle counter and a sticky mul/div timeout flag.
module hazard_ctrl_unit #(
    parameter int CNT_W      = 16,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_muldiv_i,
    input  logic             md_done_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_bubble_o,
    output logic             md_start_o,
    output logic             md_busy_o,
    output logic             md_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(MD_TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    toCnt_q, toCnt_d;
    logic             mdTimeout_q, mdTimeout_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic mdStall, brFlush, loadUse, rs1Hit, rs2Hit;

    // The done cycle releases the freeze so EX/MEM can capture the mul/div result.
    always_comb begin
        mdStall = ex_muldiv_i && !((state_q == BUSY) && md_done_i);
        brFlush = !mdStall && ex_branch_taken_i;
        rs1Hit  = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
        rs2Hit  = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
        loadUse = !mdStall && !ex_branch_taken_i && ex_mem_read_i &&
                  (ex_rd_addr_i != 5'd0) && (rs1Hit || rs2Hit);
    end

    assign pc_stall_o      = rst_n && (mdStall || loadUse);
    assign if_id_stall_o   = rst_n && (mdStall || loadUse);
    assign if_id_flush_o   = rst_n && brFlush;
    assign id_ex_stall_o   = rst_n && mdStall;
    assign id_ex_bubble_o  = rst_n && (brFlush || loadUse);
    assign ex_mem_bubble_o = rst_n && mdStall;
    assign md_start_o      = rst_n && (state_q == IDLE) && ex_muldiv_i;
    assign md_busy_o       = rst_n && (state_q == BUSY);
    assign md_timeout_o    = mdTimeout_q;
    assign stall_cycles_o  = stallCnt_q;

    always_comb begin
        state_d     = state_q;
        toCnt_d     = toCnt_q;
        mdTimeout_d = mdTimeout_q;
        stallCnt_d  = stallCnt_q;
        unique case (state_q)
            IDLE: begin
                if (ex_muldiv_i) begin
                    state_d = BUSY;
                    toCnt_d = '0;
                end
            end
            BUSY: begin
                toCnt_d = toCnt_q + TW'(1);
                if (md_done_i) begin
                    state_d = IDLE;
                end else if (toCnt_q == TO_LAST) begin
                    state_d     = IDLE;
                    mdTimeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pc_stall_o && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            toCnt_q     <= '0;
            mdTimeout_q <= 1'b0;
            stallCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            toCnt_q     <= toCnt_d;
            mdTimeout_q <= mdTimeout_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: vector table, directed multi-cycle
// sequences and randomized stimulus against a behavioural reference model.
module tb_hazard_ctrl_unit;

    localparam int CNT_W      = 4;
    localparam int MD_TIMEOUT = 8;
    localparam int SAT        = (1 << CNT_W) - 1;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, memRd, br, muldiv, done, rstN;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        logic pc, ifs, fl, ids, idb, exb, st, bs, to;
        logic [CNT_W-1:0] cnt;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic id_uses_rs1_i, id_uses_rs2_i, ex_mem_read_i, ex_branch_taken_i;
    logic ex_muldiv_i, md_done_i;
    logic pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
    logic id_ex_bubble_o, ex_mem_bubble_o, md_start_o, md_busy_o, md_timeout_o;
    logic [CNT_W-1:0] stall_cycles_o;

    int nCompared   = 0;
    int nMismatched = 0;

    bit mBusy     = 0;
    int mBusyLen  = 0;
    bit mTimeout  = 0;
    int mStalls   = 0;

    out_t lastAct;
    vec_t vq[$];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_branch_taken_i(ex_branch_taken_i), .ex_muldiv_i(ex_muldiv_i),
        .md_done_i(md_done_i), .pc_stall_o(pc_stall_o),
        .if_id_stall_o(if_id_stall_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_stall_o(id_ex_stall_o), .id_ex_bubble_o(id_ex_bubble_o),
        .ex_mem_bubble_o(ex_mem_bubble_o), .md_start_o(md_start_o),
        .md_busy_o(md_busy_o), .md_timeout_o(md_timeout_o),
        .stall_cycles_o(stall_cycles_o)
    );

    function automatic stim_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                                 input int rd, input bit memRd, input bit br,
                                 input bit muldiv, input bit done, input bit rstN);
        stim_t s;
        s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
        s.u1 = u1; s.u2 = u2; s.memRd = memRd; s.br = br;
        s.muldiv = muldiv; s.done = done; s.rstN = rstN;
        return s;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mul/div freeze wins over branch flush, which wins over load-use.
    function automatic out_t modelComb(input stim_t s);
        out_t e;
        bit hold, flush, lu;
        hold  = s.muldiv && !(mBusy && s.done);
        flush = !hold && s.br;
        lu    = !hold && !s.br && s.memRd && (s.rd != 0) &&
                ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        e.pc  = s.rstN && (hold || lu);
        e.ifs = e.pc;
        e.fl  = s.rstN && flush;
        e.ids = s.rstN && hold;
        e.idb = s.rstN && (flush || lu);
        e.exb = s.rstN && hold;
        e.st  = s.rstN && !mBusy && s.muldiv;
        e.bs  = s.rstN && mBusy;
        e.to  = mTimeout;
        e.cnt = CNT_W'(mStalls);
        return e;
    endfunction

    task automatic modelEdge(input stim_t s, input bit pcStall);
        if (!s.rstN) begin
            mBusy = 0; mBusyLen = 0; mTimeout = 0; mStalls = 0;
        end else begin
            if (pcStall && mStalls < SAT) mStalls++;
            if (!mBusy) begin
                if (s.muldiv) begin
                    mBusy = 1; mBusyLen = 0;
                end
            end else begin
                mBusyLen++;
                if (s.done) mBusy = 0;
                else if (mBusyLen == MD_TIMEOUT) begin
                    mBusy = 0; mTimeout = 1;
                end
            end
        end
    endtask

    task automatic checkOutput(input out_t a, input out_t e);
        checkVal("pc_stall",        32'(a.pc),  32'(e.pc));
        checkVal("if_id_stall",     32'(a.ifs), 32'(e.ifs));
        checkVal("if_id_flush",     32'(a.fl),  32'(e.fl));
        checkVal("id_ex_stall",     32'(a.ids), 32'(e.ids));
        checkVal("id_ex_bubble",    32'(a.idb), 32'(e.idb));
        checkVal("ex_mem_bubble",   32'(a.exb), 32'(e.exb));
        checkVal("md_start",        32'(a.st),  32'(e.st));
        checkVal("md_busy",         32'(a.bs),  32'(e.bs));
        checkVal("md_timeout",      32'(a.to),  32'(e.to));
        checkVal("stall_cycles",    32'(a.cnt), 32'(e.cnt));
    endtask

    task automatic applyStimulus(input stim_t s);
        out_t e;
        @(negedge clk);
        rst_n = s.rstN;
        id_rs1_addr_i = s.rs1; id_rs2_addr_i = s.rs2; ex_rd_addr_i = s.rd;
        id_uses_rs1_i = s.u1; id_uses_rs2_i = s.u2; ex_mem_read_i = s.memRd;
        ex_branch_taken_i = s.br; ex_muldiv_i = s.muldiv; md_done_i = s.done;
        #1;
        e = modelComb(s);
        lastAct.pc = pc_stall_o;   lastAct.ifs = if_id_stall_o;
        lastAct.fl = if_id_flush_o; lastAct.ids = id_ex_stall_o;
        lastAct.idb = id_ex_bubble_o; lastAct.exb = ex_mem_bubble_o;
        lastAct.st = md_start_o;   lastAct.bs = md_busy_o;
        lastAct.to = md_timeout_o; lastAct.cnt = stall_cycles_o;
        checkOutput(lastAct, e);
        @(posedge clk);
        modelEdge(s, e.pc);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int starts, stalls, busies;
        rst_n = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0; ex_rd_addr_i = 0;
        id_uses_rs1_i = 0; id_uses_rs2_i = 0; ex_mem_read_i = 0;
        ex_branch_taken_i = 0; ex_muldiv_i = 0; md_done_i = 0;
        repeat (2) @(posedge clk);

        // exp = {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble}
        vq.push_back('{s: mk(5, 1, 1, 1, 5, 1, 0, 0, 0, 1), exp: 6'b110010});
        vq.push_back('{s: mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 1), exp: 6'b000000});
        vq.push_back('{s: mk(2, 7, 1, 1, 7, 1, 0, 0, 0, 1), exp: 6'b110010});
        vq.push_back('{s: mk(2, 7, 1, 0, 7, 1, 0, 0, 0, 1), exp: 6'b000000});
        vq.push_back('{s: mk(9, 3, 1, 1, 9, 0, 0, 0, 0, 1), exp: 6'b000000});
        vq.push_back('{s: mk(5, 1, 1, 1, 5, 1, 1, 0, 0, 1), exp: 6'b001010});
        vq.push_back('{s: mk(4, 6, 0, 0, 8, 0, 1, 0, 0, 1), exp: 6'b001010});
        vq.push_back('{s: mk(3, 4, 1, 1, 5, 1, 0, 0, 0, 1), exp: 6'b000000});

        // Reset state and single load-use stall
        doReset();
        checkVal("reset_cnt", 32'(stall_cycles_o), 32'd0);
        checkVal("reset_timeout", 32'(md_timeout_o), 32'd0);
        applyStimulus(mk(5, 1, 1, 0, 5, 1, 0, 0, 0, 1));
        checkVal("lu_pc_stall", 32'(lastAct.pc), 32'd1);
        checkVal("lu_cnt", 32'(stall_cycles_o), 32'd1);
        applyStimulus(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 1));
        checkVal("lu_rd0_cnt", 32'(stall_cycles_o), 32'd1);
        applyStimulus(mk(5, 1, 1, 0, 5, 1, 1, 0, 0, 1));
        checkVal("br_flush", 32'(lastAct.fl), 32'd1);
        checkVal("br_cnt", 32'(stall_cycles_o), 32'd1);

        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].s);
            checkVal($sformatf("vec%0d", i),
                     32'({lastAct.pc, lastAct.ifs, lastAct.fl, lastAct.ids, lastAct.idb, lastAct.exb}),
                     32'(vq[i].exp));
        end

        // Mul/div with done on the 4th cycle after start
        doReset();
        starts = 0; stalls = 0; busies = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, (c == 4), 1));
            starts += lastAct.st; stalls += lastAct.pc; busies += lastAct.bs;
        end
        checkVal("md_done_stall", 32'(lastAct.pc), 32'd0);
        checkVal("md_starts", 32'(starts), 32'd1);
        checkVal("md_stalls", 32'(stalls), 32'd4);
        checkVal("md_busies", 32'(busies), 32'd4);
        checkVal("md_cnt", 32'(stall_cycles_o), 32'd4);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        checkVal("md_idle_after", 32'(lastAct.bs), 32'd0);

        // Timeout with no done, then a stray done in IDLE
        doReset();
        busies = 0;
        for (int c = 0; c < 9; c++) begin
            applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
            busies += lastAct.bs;
        end
        checkVal("to_busies", 32'(busies), 32'd8);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        checkVal("to_idle", 32'(lastAct.bs), 32'd0);
        checkVal("to_flag", 32'(lastAct.to), 32'd1);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        checkVal("to_stray_done", 32'(lastAct.bs), 32'd0);
        checkVal("to_sticky", 32'(lastAct.to), 32'd1);

        // Reset while BUSY, then a fresh start
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        checkVal("rb_busy", 32'(lastAct.bs), 32'd1);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        checkVal("rb_forced", 32'({lastAct.pc, lastAct.st, lastAct.bs, lastAct.exb}), 32'd0);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        checkVal("rb_restart", 32'(lastAct.st), 32'd1);
        checkVal("rb_idle", 32'(lastAct.bs), 32'd0);
        checkVal("rb_to_clear", 32'(lastAct.to), 32'd0);

        // Saturation of the 4-bit stall counter
        doReset();
        for (int c = 0; c < 20; c++) applyStimulus(mk(3, 0, 1, 0, 3, 1, 0, 0, 0, 1));
        checkVal("sat_cnt", 32'(stall_cycles_o), 32'(SAT));

        // Randomized stimulus against the model
        doReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus(mk($urandom_range(0, 3), $urandom_range(0, 3),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                             ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) != 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
